// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the byte-wide memory responder.
// MEM_RESP_FETCH_BUFFER_EN enables the single-entry fetch buffer.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DATA    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_RD   = 2'd1,
        OP_WR   = 2'd2
    } op_t;

    localparam int          BEATS = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

`ifdef MEM_RESP_FETCH_BUFFER_EN
    localparam bit FETCH_BUF_EN = 1'b1;
`else
    localparam bit FETCH_BUF_EN = 1'b0;
`endif

endpackage

// File: rtl/mem_beat_engine.sv
// Runs one four-beat little-endian byte handshake on the external bus.
// A start in the final-ack cycle chains the next access back-to-back.
module mem_beat_engine
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic              we,
    input  logic [31:0]       wdata,
    input  logic              ext_ack,
    input  logic [7:0]        ext_rdata,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [7:0]        ext_wdata,
    output logic [31:0]       word,
    output logic              done
);

    logic [1:0]  cnt;
    logic [1:0]  cnt_nxt;
    logic [31:0] wbuf;
    logic [31:0] rbuf;
    logic        beat;

    assign beat    = ext_req && ext_ack;
    assign cnt_nxt = cnt + 2'd1;
    assign done    = beat && (cnt == 2'(BEATS - 1));
    assign word    = {ext_rdata, rbuf[23:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= '0;
            cnt       <= '0;
            wbuf      <= '0;
            rbuf      <= '0;
        end else begin
            if (beat) begin
                rbuf[{cnt, 3'b000} +: 8] <= ext_rdata;
                cnt       <= cnt_nxt;
                ext_addr  <= ext_addr + ADDR_W'(1);
                ext_wdata <= wbuf[{cnt_nxt, 3'b000} +: 8];
                if (done) begin
                    ext_req <= 1'b0;
                    ext_we  <= 1'b0;
                end
            end
            // a new access overrides the wind-down of the previous one
            if (start) begin
                ext_req   <= 1'b1;
                ext_we    <= we;
                ext_addr  <= base;
                ext_wdata <= wdata[7:0];
                wbuf      <= wdata;
                cnt       <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Serves core fetch and data ports from a byte-wide memory, stalling the core.
// MEM_RESP_FETCH_BUFFER_EN skips the fetch when the last fetched word matches.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc_f,
    input  logic [31:0]       alu_result_m,
    input  logic [31:0]       write_data_m,
    input  logic              mem_write_m,
    input  logic              mem_read_m,
    output logic [31:0]       inst_f,
    output logic [31:0]       read_data_m,
    output logic              stall,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [7:0]        ext_wdata,
    input  logic [7:0]        ext_rdata,
    input  logic              ext_ack
);

    state_t            state;
    op_t               op_in;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              need_fetch;

    logic              eng_start;
    logic [ADDR_W-1:0] eng_base;
    logic              eng_we;
    logic [31:0]       eng_wdata;
    logic [31:0]       eng_word;
    logic              eng_done;

    logic unused_bits;
    assign unused_bits = ^{pc_f[31:ADDR_W], pc_f[1:0],
                           alu_result_m[31:ADDR_W], alu_result_m[1:0]};

    always_comb begin
        op_in = OP_NONE;
        if (mem_write_m)
            op_in = OP_WR;
        else if (mem_read_m)
            op_in = OP_RD;
    end

`ifdef MEM_RESP_FETCH_BUFFER_EN
    logic              buf_valid;
    logic [ADDR_W-3:0] buf_tag;
    logic [ADDR_W-3:0] pc_tag_q;

    assign need_fetch = !(buf_valid && buf_tag == pc_f[ADDR_W-1:2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            pc_tag_q  <= '0;
        end else begin
            if (state == IDLE)
                pc_tag_q <= pc_f[ADDR_W-1:2];
            if (state == FETCH && eng_done) begin
                buf_valid <= 1'b1;
                buf_tag   <= pc_tag_q;
            end
            if (state == DATA && eng_done && op_q == OP_WR
                && addr_q[ADDR_W-1:2] == buf_tag)
                buf_valid <= 1'b0;
        end
    end
`else
    assign need_fetch = 1'b1;
`endif

    // IDLE launches from the live core ports; FETCH chains the latched op
    always_comb begin
        eng_start = 1'b0;
        eng_base  = '0;
        eng_we    = 1'b0;
        eng_wdata = '0;
        unique case (state)
            IDLE: begin
                if (need_fetch) begin
                    eng_start = 1'b1;
                    eng_base  = {pc_f[ADDR_W-1:2], 2'b00};
                end else if (op_in != OP_NONE) begin
                    eng_start = 1'b1;
                    eng_base  = {alu_result_m[ADDR_W-1:2], 2'b00};
                    eng_we    = (op_in == OP_WR);
                    eng_wdata = write_data_m;
                end
            end
            FETCH: begin
                if (eng_done && op_q != OP_NONE) begin
                    eng_start = 1'b1;
                    eng_base  = addr_q;
                    eng_we    = (op_q == OP_WR);
                    eng_wdata = wdata_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            stall       <= 1'b1;
            inst_f      <= NOP;
            read_data_m <= '0;
            op_q        <= OP_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    op_q    <= op_in;
                    addr_q  <= {alu_result_m[ADDR_W-1:2], 2'b00};
                    wdata_q <= write_data_m;
                    if (need_fetch)
                        state <= FETCH;
                    else if (op_in != OP_NONE)
                        state <= DATA;
                    else begin
                        state <= RELEASE;
                        stall <= 1'b0;
                    end
                end
                FETCH: begin
                    if (eng_done) begin
                        inst_f <= eng_word;
                        if (op_q != OP_NONE)
                            state <= DATA;
                        else begin
                            state <= RELEASE;
                            stall <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (eng_done) begin
                        if (op_q == OP_RD)
                            read_data_m <= eng_word;
                        state <= RELEASE;
                        stall <= 1'b0;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    stall <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_beat_engine #(.ADDR_W(ADDR_W)) u_engine (
        .clk       (clk),
        .reset     (reset),
        .start     (eng_start),
        .base      (eng_base),
        .we        (eng_we),
        .wdata     (eng_wdata),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .word      (eng_word),
        .done      (eng_done)
    );

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the rv32i pipeline core: serves the core's instruction-fetch port (`pc_f`/`inst_f`) and data port (`alu_result_m`/`write_data_m`/`mem_write_m`/`read_data_m`) from a single byte-wide external memory bus. It drives the core's `stall` input high while it serialises each 32-bit access into four byte beats. It releases the core for exactly one cycle per completed step. It sits between the `processor` top-level ports and the chip's external memory pads.

## Interface
- `ADDR_W`, default 24: external byte-address width.
- `clk` input 1: single clock, all logic on posedge.
- `reset` input 1: synchronous, active-high.
- `pc_f` input 32: core fetch address.
- `alu_result_m` input 32: core data address.
- `write_data_m` input 32: core store data.
- `mem_write_m` input 1: core store request.
- `mem_read_m` input 1: core load request, taken from `result_src_m == 2'b01`.
- `inst_f` output 32: fetched instruction, registered.
- `read_data_m` output 32: loaded word, registered.
- `stall` output 1: to core `stall`; low for exactly one cycle per completed step.
- `ext_req` output 1: beat request.
- `ext_we` output 1: beat is a write.
- `ext_addr` output ADDR_W: beat byte address.
- `ext_wdata` output 8: write byte.
- `ext_rdata` input 8: read byte, valid in the `ext_ack` cycle.
- `ext_ack` input 1: beat accepted or completed.

## Operation
- FSM states: IDLE, FETCH, DATA, RELEASE.
- **IDLE**
  - `stall`=1.
  - Latches `pc_f`, `alu_result_m`, `write_data_m`, and the op.
  - Op priority: write > read > none. When both `mem_write_m` and `mem_read_m` are high, the access is a write.
  - Next state is FETCH if a fetch is required (always, unless the macro skips it), else DATA if an op is present, else RELEASE.
- **FETCH**
  - Four beats at `{pc[ADDR_W-1:2],2'b00}+k`, k=0..3, with `ext_we`=0.
  - Little-endian: beat k fills `inst_f[8k+7:8k]`.
  - After the 4th ack: go to DATA if an op is latched, else RELEASE.
  - `inst_f` updates only after all four bytes are collected. No partial-word visibility.
- **DATA**
  - Four beats at the word-aligned `alu_result_m` (low 2 bits forced 0).
  - Read: assembles `read_data_m` with the same little-endian rule.
  - Write: `ext_we`=1 and `ext_wdata`=`wdata[8k+7:8k]`.
  - After the 4th ack, go to RELEASE.
  - `read_data_m` is unchanged by writes.
- **RELEASE**: `stall`=0 for one cycle, then go to IDLE.
- Handshake rules:
  - `ext_req`, `ext_we`, `ext_addr`, and `ext_wdata` stay stable from assertion until the cycle `ext_ack`=1.
  - Without an ack, the beat is held indefinitely. There is no timeout.
  - `ext_ack` while `ext_req`=0 is ignored.
- Beat counter: 2 bits, wraps 3→0 on the final ack.
- Address arithmetic: modulo 2^ADDR_W. Upper `pc`/address bits above `ADDR_W` are ignored.
- Reset values:
  - state IDLE, `stall`=1.
  - `inst_f`=32'h0000_0013 (NOP), `read_data_m`=0.
  - `ext_req`=0, `ext_we`=0, `ext_addr`=0, `ext_wdata`=0, beat counter 0.
- Reset mid-transaction: the beat is abandoned and outputs take their reset values on the next edge. The partially assembled word is discarded.

## Timing
- The zero-wait external memory (ack in the same cycle as req) sets the minimum latency.
- `ext_req` is registered: it is first high in the cycle after the FSM enters FETCH or DATA.
- Fetch only: IDLE 1 + FETCH 4 + RELEASE 1 = 6-cycle step. `stall` is high for 5 cycles, low for 1.
- Fetch plus load or store: 10-cycle step.
- Each ext wait cycle adds one cycle.
- FETCH→DATA and the beat-to-beat transitions are back-to-back: `ext_req` stays high with no idle cycle between beats.
- `inst_f` and `read_data_m` are valid from the RELEASE cycle and hold until the next completion.

## Configuration
- `MEM_RESP_FETCH_BUFFER_EN` defined: keeps a valid bit and a tag register for the last fetched word address.
  - In IDLE, if the valid bit is set and the tag equals `pc_f[ADDR_W-1:2]`, FETCH is skipped and `inst_f` is reused.
  - Any DATA write to the tagged word clears the valid bit.
  - Reset clears the valid bit.
- Not defined: every step fetches.

## Structure
- Shared include/package `mem_bus_pkg` holds:
  - state encodings (IDLE=0, FETCH=1, DATA=2, RELEASE=3);
  - `BEATS`=4;
  - NOP constant 32'h0000_0013;
  - the `MEM_RESP_FETCH_BUFFER_EN` guard.
- One sub-module, `mem_beat_engine`: runs one 4-beat handshake given base address, we, and wdata. It returns the assembled word plus a `done` pulse. FETCH and DATA both reuse it.

## Test plan
- Reset with zero-wait memory, `pc_f`=0x10, memory word 0x00500093 → ext_addr 0x10..0x13; `inst_f`=0x00500093 in the RELEASE cycle, which is cycle 6 after reset deassertion; `stall` low exactly that cycle.
- Store: `mem_write_m`=1, `alu_result_m`=0x64, `write_data_m`=25 → after the fetch, beats at 0x64..0x67 carry 0x19,0x00,0x00,0x00 with `ext_we`=1; step is 10 cycles.
- Load with `ext_ack` delayed 2 cycles per beat, word 0xDEADBEEF at 0x200 → `read_data_m`=0xDEADBEEF; step is 1+12+12+1=26 cycles; `ext_addr` stable through each wait.
- Both `mem_read_m` and `mem_write_m` set → a write is performed and `read_data_m` is unchanged.
- Reset asserted on the 2nd ack of a fetch → next cycle `ext_req`=0, `inst_f`=0x13, `stall`=1.
- With `MEM_RESP_FETCH_BUFFER_EN`, same `pc_f` twice → second step has no fetch beats and takes 2 cycles; after a store to that word, the next step refetches.
